// File: rtl/riscv_pkg.sv
// Shared RV32I definitions: ALU opcodes, forwarding selects and pipeline control bundle.
package riscv_pkg;
    localparam int REG_W = 5;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLL = 4'b0100;

    typedef enum logic [1:0] {
        FWD_RF    = 2'd0,
        FWD_EXMEM = 2'd1,
        FWD_MEMWB = 2'd2
    } fwd_sel_e;

    typedef struct packed {
        logic regwrite;
        logic memread;
        logic memwrite;
        logic branch;
        logic memtoreg;
    } ctrl_t;
endpackage

// File: rtl/fwd_mux.sv
// Operand forwarding select: the youngest producer (EX/MEM) wins over MEM/WB, x0 never forwards.
module fwd_mux
    import riscv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [REG_W-1:0] rs_i,
    input  logic [XLEN-1:0]  rf_data_i,
    input  logic [REG_W-1:0] exmem_rd_i,
    input  logic             exmem_regwrite_i,
    input  logic [XLEN-1:0]  exmem_data_i,
    input  logic [REG_W-1:0] memwb_rd_i,
    input  logic             memwb_regwrite_i,
    input  logic [XLEN-1:0]  memwb_data_i,
    output logic [XLEN-1:0]  data_o
);
    fwd_sel_e sel;

    always_comb begin
        sel = FWD_RF;
        if (exmem_regwrite_i && (exmem_rd_i != '0) && (exmem_rd_i == rs_i)) begin
            sel = FWD_EXMEM;
        end else if (memwb_regwrite_i && (memwb_rd_i != '0) && (memwb_rd_i == rs_i)) begin
            sel = FWD_MEMWB;
        end
    end

    always_comb begin
        data_o = rf_data_i;
        case (sel)
            FWD_EXMEM: data_o = exmem_data_i;
            FWD_MEMWB: data_o = memwb_data_i;
            default:   data_o = rf_data_i;
        endcase
    end
endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall detection, bubble insertion and
// operand forwarding into the ALU inputs.
module id_ex_stage
    import riscv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [XLEN-1:0]  id_pc,
    input  logic [XLEN-1:0]  id_rs1_data,
    input  logic [XLEN-1:0]  id_rs2_data,
    input  logic [XLEN-1:0]  id_imm,
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic [REG_W-1:0] id_rd,
    input  logic [3:0]       id_alu_control,
    input  logic             id_alusrc,
    input  logic             id_regwrite,
    input  logic             id_memread,
    input  logic             id_memwrite,
    input  logic             id_branch,
    input  logic             id_memtoreg,
    input  logic             flush,
    input  logic [REG_W-1:0] exmem_rd,
    input  logic             exmem_regwrite,
    input  logic [XLEN-1:0]  exmem_data,
    input  logic [REG_W-1:0] memwb_rd,
    input  logic             memwb_regwrite,
    input  logic [XLEN-1:0]  memwb_data,
    output logic             stall,
    output logic [3:0]       control,
    output logic [XLEN-1:0]  entrada0,
    output logic [XLEN-1:0]  entrada1,
    output logic [XLEN-1:0]  ex_store_data,
    output logic             ex_valid,
    output logic [XLEN-1:0]  ex_pc,
    output logic [REG_W-1:0] ex_rd,
    output logic             ex_regwrite,
    output logic             ex_memread,
    output logic             ex_memwrite,
    output logic             ex_branch,
    output logic             ex_memtoreg
);
    logic             valid_q,       valid_d;
    logic [XLEN-1:0]  pc_q,          pc_d;
    logic [XLEN-1:0]  rs1_data_q,    rs1_data_d;
    logic [XLEN-1:0]  rs2_data_q,    rs2_data_d;
    logic [XLEN-1:0]  imm_q,         imm_d;
    logic [REG_W-1:0] rs1_q,         rs1_d;
    logic [REG_W-1:0] rs2_q,         rs2_d;
    logic [REG_W-1:0] rd_q,          rd_d;
    logic [3:0]       alu_control_q, alu_control_d;
    logic             alusrc_q,      alusrc_d;
    ctrl_t            ctrl_q,        ctrl_d;

    logic [XLEN-1:0]  fwd_rs1, fwd_rs2;

    // Conservative: any match on rs1 or rs2 stalls, whether or not rs2 is read.
    assign stall = valid_q & ctrl_q.memread & (rd_q != '0) & id_valid
                 & ((rd_q == id_rs1) | (rd_q == id_rs2));

    always_comb begin
        valid_d       = 1'b0;
        pc_d          = '0;
        rs1_data_d    = '0;
        rs2_data_d    = '0;
        imm_d         = '0;
        rs1_d         = '0;
        rs2_d         = '0;
        rd_d          = '0;
        alu_control_d = ALU_ADD;
        alusrc_d      = 1'b0;
        ctrl_d        = '0;
        if (!(stall || flush)) begin
            valid_d       = id_valid;
            pc_d          = id_pc;
            rs1_data_d    = id_rs1_data;
            rs2_data_d    = id_rs2_data;
            imm_d         = id_imm;
            rs1_d         = id_rs1;
            rs2_d         = id_rs2;
            rd_d          = id_rd;
            alu_control_d = id_alu_control;
            alusrc_d      = id_alusrc;
            if (id_valid) begin
                ctrl_d = '{regwrite: id_regwrite, memread: id_memread, memwrite: id_memwrite,
                           branch: id_branch, memtoreg: id_memtoreg};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q       <= 1'b0;
            pc_q          <= '0;
            rs1_data_q    <= '0;
            rs2_data_q    <= '0;
            imm_q         <= '0;
            rs1_q         <= '0;
            rs2_q         <= '0;
            rd_q          <= '0;
            alu_control_q <= ALU_ADD;
            alusrc_q      <= 1'b0;
            ctrl_q        <= '0;
        end else begin
            valid_q       <= valid_d;
            pc_q          <= pc_d;
            rs1_data_q    <= rs1_data_d;
            rs2_data_q    <= rs2_data_d;
            imm_q         <= imm_d;
            rs1_q         <= rs1_d;
            rs2_q         <= rs2_d;
            rd_q          <= rd_d;
            alu_control_q <= alu_control_d;
            alusrc_q      <= alusrc_d;
            ctrl_q        <= ctrl_d;
        end
    end

    fwd_mux #(.XLEN(XLEN)) u_fwd_rs1 (
        .rs_i(rs1_q), .rf_data_i(rs1_data_q),
        .exmem_rd_i(exmem_rd), .exmem_regwrite_i(exmem_regwrite), .exmem_data_i(exmem_data),
        .memwb_rd_i(memwb_rd), .memwb_regwrite_i(memwb_regwrite), .memwb_data_i(memwb_data),
        .data_o(fwd_rs1)
    );

    fwd_mux #(.XLEN(XLEN)) u_fwd_rs2 (
        .rs_i(rs2_q), .rf_data_i(rs2_data_q),
        .exmem_rd_i(exmem_rd), .exmem_regwrite_i(exmem_regwrite), .exmem_data_i(exmem_data),
        .memwb_rd_i(memwb_rd), .memwb_regwrite_i(memwb_regwrite), .memwb_data_i(memwb_data),
        .data_o(fwd_rs2)
    );

    assign control       = alu_control_q;
    assign entrada0      = fwd_rs1;
    assign entrada1      = alusrc_q ? imm_q : fwd_rs2;
    assign ex_store_data = fwd_rs2;
    assign ex_valid      = valid_q;
    assign ex_pc         = pc_q;
    assign ex_rd         = rd_q;
    assign ex_regwrite   = ctrl_q.regwrite;
    assign ex_memread    = ctrl_q.memread;
    assign ex_memwrite   = ctrl_q.memwrite;
    assign ex_branch     = ctrl_q.branch;
    assign ex_memtoreg   = ctrl_q.memtoreg;
endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: per-cycle comparison against a behavioural model
// plus literal expectations at the interesting points of each scenario.
module tb_id_ex_stage;
    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic [3:0]  id_alu_control;
    logic        id_alusrc, id_regwrite, id_memread, id_memwrite, id_branch, id_memtoreg;
    logic        flush;
    logic [4:0]  exmem_rd, memwb_rd;
    logic        exmem_regwrite, memwb_regwrite;
    logic [31:0] exmem_data, memwb_data;
    logic        stall;
    logic [3:0]  control;
    logic [31:0] entrada0, entrada1, ex_store_data, ex_pc;
    logic        ex_valid, ex_regwrite, ex_memread, ex_memwrite, ex_branch, ex_memtoreg;
    logic [4:0]  ex_rd;

    int errors = 0;
    int checks = 0;

    id_ex_stage #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_pc(id_pc),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_alu_control(id_alu_control),
        .id_alusrc(id_alusrc), .id_regwrite(id_regwrite), .id_memread(id_memread),
        .id_memwrite(id_memwrite), .id_branch(id_branch), .id_memtoreg(id_memtoreg),
        .flush(flush), .exmem_rd(exmem_rd), .exmem_regwrite(exmem_regwrite),
        .exmem_data(exmem_data), .memwb_rd(memwb_rd), .memwb_regwrite(memwb_regwrite),
        .memwb_data(memwb_data), .stall(stall), .control(control), .entrada0(entrada0),
        .entrada1(entrada1), .ex_store_data(ex_store_data), .ex_valid(ex_valid),
        .ex_pc(ex_pc), .ex_rd(ex_rd), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
        .ex_memwrite(ex_memwrite), .ex_branch(ex_branch), .ex_memtoreg(ex_memtoreg)
    );

    always #5 clk = ~clk;

    // Model: what instruction sits in EX, as plain fields.
    logic        m_started = 1'b0;
    logic        m_valid;
    logic [31:0] m_pc, m_r1d, m_r2d, m_imm;
    logic [4:0]  m_rs1, m_rs2, m_rd;
    logic [3:0]  m_op;
    logic        m_alusrc, m_rw, m_mr, m_mw, m_br, m_mt;

    function automatic logic model_stall();
        if (!m_started || !m_valid || !m_mr || m_rd == 5'd0 || !id_valid) return 1'b0;
        return (m_rd == id_rs1) || (m_rd == id_rs2);
    endfunction

    function automatic logic [31:0] model_fwd(input logic [4:0] r, input logic [31:0] rf);
        if (exmem_regwrite && exmem_rd != 5'd0 && exmem_rd == r) return exmem_data;
        if (memwb_regwrite && memwb_rd != 5'd0 && memwb_rd == r) return memwb_data;
        return rf;
    endfunction

    always @(posedge clk) begin
        logic bubble;
        bubble = rst || model_stall() || flush;
        if (rst) m_started = 1'b1;
        if (bubble) begin
            m_valid = 0; m_pc = 0; m_r1d = 0; m_r2d = 0; m_imm = 0;
            m_rs1 = 0; m_rs2 = 0; m_rd = 0; m_op = 4'b0010; m_alusrc = 0;
            {m_rw, m_mr, m_mw, m_br, m_mt} = 5'b0;
        end else begin
            m_valid = id_valid; m_pc = id_pc; m_r1d = id_rs1_data; m_r2d = id_rs2_data;
            m_imm = id_imm; m_rs1 = id_rs1; m_rs2 = id_rs2; m_rd = id_rd;
            m_op = id_alu_control; m_alusrc = id_alusrc;
            if (id_valid) {m_rw, m_mr, m_mw, m_br, m_mt} =
                {id_regwrite, id_memread, id_memwrite, id_branch, id_memtoreg};
            else {m_rw, m_mr, m_mw, m_br, m_mt} = 5'b0;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (m_started) begin
            logic [31:0] f2;
            f2 = model_fwd(m_rs2, m_r2d);
            chk("m_stall", {31'b0, stall}, {31'b0, model_stall()});
            chk("m_control", {28'b0, control}, {28'b0, m_op});
            chk("m_entrada0", entrada0, model_fwd(m_rs1, m_r1d));
            chk("m_entrada1", entrada1, m_alusrc ? m_imm : f2);
            chk("m_store", ex_store_data, f2);
            chk("m_pc", ex_pc, m_pc);
            chk("m_rd", {27'b0, ex_rd}, {27'b0, m_rd});
            chk("m_ctl", {25'b0, ex_valid, ex_regwrite, ex_memread, ex_memwrite, ex_branch,
                          ex_memtoreg, 1'b0},
                {25'b0, m_valid, m_rw, m_mr, m_mw, m_br, m_mt, 1'b0});
        end
    end

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_fwd();
        exmem_rd = 0; exmem_regwrite = 0; exmem_data = 0;
        memwb_rd = 0; memwb_regwrite = 0; memwb_data = 0;
    endtask

    // ctl = {regwrite, memread, memwrite, branch, memtoreg}
    task automatic instr(input logic v, input logic [31:0] pc, input logic [4:0] r1,
                         input logic [4:0] r2, input logic [4:0] rd, input logic [31:0] d1,
                         input logic [31:0] d2, input logic [31:0] imm, input logic [3:0] op,
                         input logic asrc, input logic [4:0] ctl);
        id_valid = v; id_pc = pc; id_rs1 = r1; id_rs2 = r2; id_rd = rd;
        id_rs1_data = d1; id_rs2_data = d2; id_imm = imm; id_alu_control = op;
        id_alusrc = asrc;
        {id_regwrite, id_memread, id_memwrite, id_branch, id_memtoreg} = ctl;
    endtask

    initial begin
        rst = 1; flush = 0;
        clr_fwd();
        instr(0, 0, 0, 0, 0, 0, 0, 0, 4'b0010, 0, 5'b0);
        nxt(); nxt();
        chk("rst_control", {28'b0, control}, 32'h2);
        rst = 0;
        nxt();
        chk("idle_control", {28'b0, control}, 32'h2);
        chk("idle_e0", entrada0, 32'h0);
        chk("idle_e1", entrada1, 32'h0);
        chk("idle_valid", {31'b0, ex_valid}, 32'h0);
        chk("idle_stall", {31'b0, stall}, 32'h0);

        // ADD x3,x1,x2
        instr(1, 32'h100, 1, 2, 3, 5, 7, 0, 4'b0010, 0, 5'b10000);
        nxt();
        chk("add_e0", entrada0, 32'd5);
        chk("add_e1", entrada1, 32'd7);
        chk("add_ctl", {28'b0, control}, 32'h2);
        chk("add_rd", {27'b0, ex_rd}, 32'd3);
        chk("add_rw", {31'b0, ex_regwrite}, 32'h1);

        // double hazard on rs1 = x4
        instr(1, 32'h104, 4, 6, 8, 32'h111, 32'h222, 0, 4'b0001, 0, 5'b10000);
        nxt();
        exmem_rd = 4; exmem_regwrite = 1; exmem_data = 32'h10;
        memwb_rd = 4; memwb_regwrite = 1; memwb_data = 32'h20;
        #1 chk("dh_exmem", entrada0, 32'h10);
        exmem_regwrite = 0;
        #1 chk("dh_memwb", entrada0, 32'h20);
        instr(1, 32'h108, 0, 6, 8, 32'h55, 32'h222, 0, 4'b0001, 0, 5'b10000);
        exmem_rd = 0; exmem_regwrite = 1; memwb_rd = 0;
        nxt();
        chk("x0_nofwd", entrada0, 32'h55);
        clr_fwd();

        // load-use: LW x5 then SUB x7,x6,x5
        instr(1, 32'h10C, 1, 0, 5, 32'h40, 0, 4, 4'b0010, 1, 5'b11001);
        nxt();
        instr(1, 32'h110, 6, 5, 7, 32'h9, 32'h1, 0, 4'b0110, 0, 5'b10000);
        #1 chk("lu_stall", {31'b0, stall}, 32'h1);
        nxt();
        chk("lu_bub_valid", {31'b0, ex_valid}, 32'h0);
        chk("lu_bub_ctl", {27'b0, ex_regwrite, ex_memread, ex_memwrite, ex_branch,
                           ex_memtoreg}, 32'h0);
        chk("lu_stall_drop", {31'b0, stall}, 32'h0);
        nxt();
        memwb_rd = 5; memwb_regwrite = 1; memwb_data = 32'hABC;
        #1;
        chk("lu_sub_ctl", {28'b0, control}, 32'h6);
        chk("lu_sub_rd", {27'b0, ex_rd}, 32'd7);
        chk("lu_sub_fwd", entrada1, 32'hABC);
        clr_fwd();

        // ADDI with immediate, rs2 forwarded
        instr(1, 32'h114, 2, 9, 10, 32'h3, 32'h0, 32'hFFFF_FFFC, 4'b0010, 1, 5'b10000);
        nxt();
        exmem_rd = 9; exmem_regwrite = 1; exmem_data = 32'h99;
        #1;
        chk("addi_e1", entrada1, 32'hFFFF_FFFC);
        chk("addi_store", ex_store_data, 32'h99);
        clr_fwd();

        // flush with a valid SW
        instr(1, 32'h118, 2, 3, 0, 32'h1, 32'h2, 8, 4'b0010, 1, 5'b00100);
        flush = 1;
        nxt();
        flush = 0;
        chk("flush_mw", {31'b0, ex_memwrite}, 32'h0);
        chk("flush_valid", {31'b0, ex_valid}, 32'h0);

        // invalid slot: control bits dropped, pc still captured
        instr(0, 32'h11C, 1, 2, 3, 0, 0, 0, 4'b0010, 0, 5'b10100);
        nxt();
        chk("inv_ctl", {30'b0, ex_regwrite, ex_memwrite}, 32'h0);
        chk("inv_pc", ex_pc, 32'h11C);

        // reset while stalled
        instr(1, 32'h120, 1, 0, 5, 32'h40, 0, 4, 4'b0010, 1, 5'b11001);
        nxt();
        instr(1, 32'h124, 5, 2, 7, 32'h9, 32'h1, 0, 4'b0110, 0, 5'b10000);
        #1 chk("rs_stall", {31'b0, stall}, 32'h1);
        rst = 1;
        nxt();
        chk("rs_valid", {31'b0, ex_valid}, 32'h0);
        chk("rs_ctl", {28'b0, control}, 32'h2);
        chk("rs_pc", ex_pc, 32'h0);
        chk("rs_e0", entrada0, 32'h0);
        chk("rs_stall0", {31'b0, stall}, 32'h0);
        rst = 0;

        // short mixed sweep, checked by the model only
        for (int i = 0; i < 40; i++) begin
            instr(1'($urandom_range(0, 3) != 0), $urandom, 5'($urandom_range(0, 6)),
                  5'($urandom_range(0, 6)), 5'($urandom_range(0, 6)), $urandom, $urandom,
                  $urandom, 4'b0010, 1'($urandom), 5'($urandom));
            flush = ($urandom_range(0, 7) == 0);
            exmem_rd = 5'($urandom_range(0, 6)); exmem_regwrite = 1'($urandom);
            exmem_data = $urandom;
            memwb_rd = 5'($urandom_range(0, 6)); memwb_regwrite = 1'($urandom);
            memwb_data = $urandom;
            nxt();
        end
        flush = 0;
        nxt();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
